ap_ctrl_perf_monitor: RTL and testbench

Synthesizable, parametrised performance monitor for `NUM_CH` HLS block-level handshake interfaces (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`). Per channel, it counts accepted starts and completed transactions, and pairs them in order through a timestamp FIFO to measure latency (min/max/sum) and initiation interval. It supports pipelined kernels with several outstanding transactions. It sits beside the kernels under the dataflow monitor layer and exposes results through a registered read port, so both cosim and on-chip debug can harvest statistics after `finish`.

---
 rtl/ap_ctrl_perf_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_perf_monitor.sv
// Performance monitor for HLS ap_ctrl handshakes: per-channel start/done counts,
// in-order latency pairing through a timestamp FIFO, initiation interval, and a registered read port.
module ap_ctrl_perf_monitor #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int DEPTH  = 8,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              finish,
   input  logic [NUM_CH-1:0] ap_start,
   input  logic [NUM_CH-1:0] ap_ready,
   input  logic [NUM_CH-1:0] ap_done,
   input  logic [NUM_CH-1:0] ap_continue,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [2:0]        rd_field,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic              frozen,
   output logic [NUM_CH-1:0] err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic [CNT_W-1:0] now_q, now_d;
   logic             frozen_q, frozen_d;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   // Per-channel statistics gathered for the read mux, indexed by field number.
   logic [CNT_W-1:0] stat [NUM_CH][8];

   always_comb begin
      frozen_d = frozen_q | finish;
      now_d    = frozen_q ? now_q : now_q + 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
         logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
         logic [CNT_W-1:0] min_lat_q, min_lat_d;
         logic [CNT_W-1:0] max_lat_q, max_lat_d;
         logic [CNT_W-1:0] lat_sum_q, lat_sum_d;
         logic [CNT_W-1:0] last_ii_q, last_ii_d;
         logic [CNT_W-1:0] prev_ts_q, prev_ts_d;
         logic             has_prev_q, has_prev_d;
         logic             err_q, err_d;
         logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
         logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
         logic [PTR_W:0]   cnt_q, cnt_d;
         logic [CNT_W-1:0] mem [DEPTH];
         logic [CNT_W-1:0] head;
         logic [CNT_W-1:0] lat;
         logic [CNT_W:0]   sum_ext;
         logic             st_ev, dn_ev, empty, full;
         logic             push, pop, lat_vld;

         assign st_ev = ap_start[gi] & ap_ready[gi];
         assign dn_ev = ap_done[gi] & ap_continue[gi];
         assign empty = (cnt_q == '0);
         assign full  = (cnt_q == FULL_CNT);
         // Head is read asynchronously so a done can pair with it in the same cycle.
         assign head  = mem[rd_ptr_q];

         always_comb begin
            start_cnt_d = start_cnt_q;
            done_cnt_d  = done_cnt_q;
            min_lat_d   = min_lat_q;
            max_lat_d   = max_lat_q;
            lat_sum_d   = lat_sum_q;
            last_ii_d   = last_ii_q;
            prev_ts_d   = prev_ts_q;
            has_prev_d  = has_prev_q;
            err_d       = err_q;
            push        = 1'b0;
            pop         = 1'b0;
            lat_vld     = 1'b0;
            lat         = '0;
            if (!frozen_q) begin
               if (st_ev) begin
                  start_cnt_d = sat_inc(start_cnt_q);
                  if (has_prev_q) begin
                     last_ii_d = now_q - prev_ts_q;
                  end
                  prev_ts_d  = now_q;
                  has_prev_d = 1'b1;
               end
               if (dn_ev) begin
                  done_cnt_d = sat_inc(done_cnt_q);
                  if (!empty) begin
                     pop     = 1'b1;
                     lat     = now_q - head;
                     lat_vld = 1'b1;
                  end else if (st_ev) begin
                     lat_vld = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               if (st_ev) begin
                  if (empty && dn_ev) begin
                     push = 1'b0;
                  end else if (full && !dn_ev) begin
                     err_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end
            end
            sum_ext = {1'b0, lat_sum_q} + {1'b0, lat};
            if (lat_vld) begin
               if (lat < min_lat_q) min_lat_d = lat;
               if (lat > max_lat_q) max_lat_d = lat;
               lat_sum_d = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
            end
            wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            cnt_d    = cnt_q;
            if (push && !pop) cnt_d = cnt_q + 1'b1;
            if (pop && !push) cnt_d = cnt_q - 1'b1;
         end

         always_ff @(posedge clock) begin
            if (push) begin
               mem[wr_ptr_q] <= now_q;
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               start_cnt_q <= '0;
               done_cnt_q  <= '0;
               min_lat_q   <= '1;
               max_lat_q   <= '0;
               lat_sum_q   <= '0;
               last_ii_q   <= '0;
               prev_ts_q   <= '0;
               has_prev_q  <= 1'b0;
               err_q       <= 1'b0;
               wr_ptr_q    <= '0;
               rd_ptr_q    <= '0;
               cnt_q       <= '0;
            end else begin
               start_cnt_q <= start_cnt_d;
               done_cnt_q  <= done_cnt_d;
               min_lat_q   <= min_lat_d;
               max_lat_q   <= max_lat_d;
               lat_sum_q   <= lat_sum_d;
               last_ii_q   <= last_ii_d;
               prev_ts_q   <= prev_ts_d;
               has_prev_q  <= has_prev_d;
               err_q       <= err_d;
               wr_ptr_q    <= wr_ptr_d;
               rd_ptr_q    <= rd_ptr_d;
               cnt_q       <= cnt_d;
            end
         end

         assign err[gi]     = err_q;
         assign stat[gi][0] = start_cnt_q;
         assign stat[gi][1] = done_cnt_q;
         assign stat[gi][2] = min_lat_q;
         assign stat[gi][3] = max_lat_q;
         assign stat[gi][4] = lat_sum_q;
         assign stat[gi][5] = last_ii_q;
         assign stat[gi][6] = CNT_W'(cnt_q);
         assign stat[gi][7] = '0;
      end
   endgenerate

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      if (rd_en) begin
         rd_data_d = '0;
         if (rd_field == 3'd7) begin
            rd_data_d = now_q;
         end else begin
            // Unmatched channel numbers fall through to zero.
            for (int i = 0; i < NUM_CH; i++) begin
               if (rd_ch == CH_W'(i)) rd_data_d = stat[i][rd_field];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         now_q      <= '0;
         frozen_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         now_q      <= now_d;
         frozen_q   <= frozen_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign frozen   = frozen_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_ap_ctrl_perf_monitor;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 32;
   localparam int DEPTH  = 8;
   localparam int CH_W   = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              finish;
   logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
   logic              rd_en;
   logic [CH_W-1:0]   rd_ch;
   logic [2:0]        rd_field;
   logic              rd_valid;
   logic [CNT_W-1:0]  rd_data;
   logic              frozen;
   logic [NUM_CH-1:0] err;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   always #5 clock = ~clock;

   ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .finish(finish),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
      .rd_valid(rd_valid), .rd_data(rd_data), .frozen(frozen), .err(err)
   );

   // Reference model: a timestamp list per channel, shifted on pop.
   logic [31:0]       m_now;
   bit                m_frozen;
   logic [31:0]       m_start [NUM_CH];
   logic [31:0]       m_done  [NUM_CH];
   logic [31:0]       m_min   [NUM_CH];
   logic [31:0]       m_max   [NUM_CH];
   logic [31:0]       m_sum   [NUM_CH];
   logic [31:0]       m_ii    [NUM_CH];
   logic [31:0]       m_prev  [NUM_CH];
   bit                m_has_prev [NUM_CH];
   logic [31:0]       m_fifo  [NUM_CH][DEPTH];
   int                m_n     [NUM_CH];
   logic [NUM_CH-1:0] m_err;
   bit                exp_valid;
   logic [31:0]       exp_data;

   function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, expv, $time);
      end
   endfunction

   function automatic void model_reset();
      m_now    = 0;
      m_frozen = 0;
      m_err    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_start[c] = 0; m_done[c] = 0; m_min[c] = 32'hFFFF_FFFF; m_max[c] = 0;
         m_sum[c] = 0; m_ii[c] = 0; m_prev[c] = 0; m_has_prev[c] = 0; m_n[c] = 0;
      end
   endfunction

   function automatic logic [31:0] model_read(int ch, int f);
      if (f == 7) return m_now;
      if (ch >= NUM_CH) return 0;
      case (f)
         0: return m_start[ch];
         1: return m_done[ch];
         2: return m_min[ch];
         3: return m_max[ch];
         4: return m_sum[ch];
         5: return m_ii[ch];
         default: return 32'(m_n[ch]);
      endcase
   endfunction

   function automatic void model_channel(int c, bit s, bit d);
      int          n0 = m_n[c];
      bit          have_lat = 0;
      logic [31:0] lat = 0;
      logic [32:0] wide;
      if (s) begin
         if (m_start[c] != 32'hFFFF_FFFF) m_start[c] = m_start[c] + 1;
         if (m_has_prev[c]) m_ii[c] = m_now - m_prev[c];
         m_prev[c] = m_now;
         m_has_prev[c] = 1;
      end
      if (d) begin
         if (m_done[c] != 32'hFFFF_FFFF) m_done[c] = m_done[c] + 1;
         if (n0 > 0) begin
            lat = m_now - m_fifo[c][0];
            for (int k = 0; k < DEPTH - 1; k++) m_fifo[c][k] = m_fifo[c][k+1];
            m_n[c] = m_n[c] - 1;
            have_lat = 1;
         end else if (s) begin
            have_lat = 1;
         end else begin
            m_err[c] = 1'b1;
         end
      end
      if (s && !(d && n0 == 0)) begin
         if (n0 == DEPTH && !d) m_err[c] = 1'b1;
         else begin
            m_fifo[c][m_n[c]] = m_now;
            m_n[c] = m_n[c] + 1;
         end
      end
      if (have_lat) begin
         if (lat < m_min[c]) m_min[c] = lat;
         if (lat > m_max[c]) m_max[c] = lat;
         wide = {1'b0, m_sum[c]} + {1'b0, lat};
         m_sum[c] = wide[32] ? 32'hFFFF_FFFF : wide[31:0];
      end
   endfunction

   initial begin
      model_reset();
      exp_valid = 0;
      exp_data  = 0;
      forever begin
         @(posedge clock);
         if (reset) begin
            model_reset();
            exp_valid = 0;
            exp_data  = 0;
         end else begin
            exp_valid = rd_en;
            if (rd_en) exp_data = model_read(int'(rd_ch), int'(rd_field));
            if (!m_frozen) begin
               for (int c = 0; c < NUM_CH; c++)
                  model_channel(c, ap_start[c] & ap_ready[c], ap_done[c] & ap_continue[c]);
               m_now = m_now + 1;
            end
            if (finish) m_frozen = 1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            check("rd_valid", 32'(rd_valid), 32'(exp_valid));
            check("rd_data", rd_data, exp_data);
            check("frozen", 32'(frozen), 32'(m_frozen));
            check("err", 32'(err), 32'(m_err));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic idle_in();
      ap_start = '0; ap_done = '0; ap_ready = '1; ap_continue = '1;
      finish = 1'b0; rd_en = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic rd_chk(input int ch, input int f, input logic [31:0] expv, input string name);
      rd_en = 1'b1; rd_ch = CH_W'(ch); rd_field = 3'(f);
      step();
      rd_en = 1'b0;
      check(name, rd_data, expv);
      check({name, "_valid"}, 32'(rd_valid), 32'd1);
      $display("read ch=%0d field=%0d data=%0d (%s)", ch, f, rd_data, name);
   endtask

   initial begin
      int pst [NUM_CH];
      int pdn [NUM_CH];
      idle_in();
      rd_ch = '0; rd_field = '0; reset = 1'b1;
      step();
      chk_en = 1'b1;
      check("reset_rd_valid", 32'(rd_valid), 32'd0);
      check("reset_rd_data", rd_data, 32'd0);

      // Single transaction: start at now=10, done at now=25.
      do_reset();
      repeat (10) step();
      ap_start[0] = 1'b1; step(); ap_start[0] = 1'b0;
      repeat (14) step();
      ap_done[0] = 1'b1; step(); ap_done[0] = 1'b0;
      rd_chk(0, 0, 1, "single_start");
      rd_chk(0, 1, 1, "single_done");
      rd_chk(0, 2, 15, "single_min");
      rd_chk(0, 3, 15, "single_max");
      rd_chk(0, 4, 15, "single_sum");
      rd_chk(0, 6, 0, "single_occ");

      // Pipelined: starts at 0,4,8 and dones at 20,24,28 on channel 1.
      do_reset();
      for (int k = 0; k <= 28; k++) begin
         ap_start[1] = (k == 0 || k == 4 || k == 8);
         ap_done[1]  = (k == 20 || k == 24 || k == 28);
         rd_en = (k == 10); rd_ch = 2'd1; rd_field = 3'd6;
         step();
         if (k == 10) check("pipe_occ_peak", rd_data, 3);
      end
      idle_in();
      rd_chk(1, 2, 20, "pipe_min");
      rd_chk(1, 3, 20, "pipe_max");
      rd_chk(1, 4, 60, "pipe_sum");
      rd_chk(1, 5, 4, "pipe_ii");
      check("pipe_err", 32'(err), 32'd0);

      // Combinational handshake on an empty FIFO.
      do_reset();
      ap_start[2] = 1'b1; ap_done[2] = 1'b1; step(); idle_in();
      rd_chk(2, 2, 0, "comb_min");
      rd_chk(2, 1, 1, "comb_done");
      rd_chk(2, 6, 0, "comb_occ");
      check("comb_err", 32'(err), 32'd0);

      // Overflow on channel 0, then a spurious done on channel 2.
      do_reset();
      ap_start[0] = 1'b1; repeat (9) step(); idle_in();
      check("ovf_err", 32'(err), 32'b001);
      rd_chk(0, 0, 9, "ovf_start");
      rd_chk(0, 6, 8, "ovf_occ");
      ap_done[2] = 1'b1; step(); idle_in();
      check("udf_err", 32'(err), 32'b101);
      rd_chk(2, 2, 32'hFFFF_FFFF, "udf_min");
      rd_chk(2, 4, 0, "udf_sum");
      rd_chk(2, 1, 1, "udf_done");

      // Out-of-range channel, valid drop, then reset clears outputs.
      rd_chk(3, 0, 0, "oob_read");
      step();
      check("valid_drop", 32'(rd_valid), 32'd0);
      rd_chk(0, 0, 9, "hold_src");
      step();
      check("rd_data_hold", rd_data, 9);
      reset = 1'b1; step();
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_data", rd_data, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b0;

      // Freeze: the start sampled with finish counts, later ones do not.
      do_reset();
      ap_start[1] = 1'b1; step();
      finish = 1'b1; step(); finish = 1'b0;
      check("frozen_set", 32'(frozen), 32'd1);
      repeat (3) step();
      idle_in();
      rd_chk(1, 0, 2, "frz_start");
      rd_chk(1, 5, 1, "frz_ii");
      rd_chk(1, 6, 2, "frz_occ");
      rd_chk(1, 7, 2, "frz_now_a");
      rd_chk(0, 7, 2, "frz_now_b");
      do_reset();
      check("frozen_clr", 32'(frozen), 32'd0);

      // Randomized traffic with per-segment rates.
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 400 == 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
               pst[c] = int'($urandom_range(90));
               pdn[c] = int'($urandom_range(90));
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            ap_start[c]    = ($urandom_range(99) < pst[c]);
            ap_ready[c]    = ($urandom_range(99) < 75);
            ap_done[c]     = ($urandom_range(99) < pdn[c]);
            ap_continue[c] = ($urandom_range(99) < 80);
         end
         rd_en    = ($urandom_range(1) == 1);
         rd_ch    = CH_W'($urandom_range(3));
         rd_field = 3'($urandom_range(7));
         finish   = (cyc == 3300);
         reset    = (cyc == 3600) || ($urandom_range(999) == 0);
         step();
      end
      idle_in();
      reset = 1'b0;
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
